sdram_wb_arbiter: RTL and testbench

SDRAM_WB_ARBITER -- requirements
Module: sdram_wb_arbiter

---
 rtl/sdram_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_sdram_wb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wb_arbiter.sv
// Two-master wishbone arbiter in front of a single SDRAM bridge port.
// Define SDRAM_ARB_RR_EN for round-robin; default is fixed m0 priority.
module sdram_wb_arbiter #(
  parameter int AW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_writedata,
  output logic [DW-1:0] m0_readdata,
  input  logic          m0_strobe,
  input  logic          m0_cycle,
  input  logic          m0_write,
  output logic          m0_ack,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_writedata,
  output logic [DW-1:0] m1_readdata,
  input  logic          m1_strobe,
  input  logic          m1_cycle,
  input  logic          m1_write,
  output logic          m1_ack,
  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_writedata,
  input  logic [DW-1:0] s_readdata,
  output logic          s_strobe,
  output logic          s_cycle,
  output logic          s_write,
  input  logic          s_ack,
  output logic [1:0]    grant
);

  typedef enum logic [2:0] {
    IDLE,
    OWN0,
    OWN1,
    GAP,
    DRAIN
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       req0, req1, pick1;

  assign req0 = m0_cycle & m0_strobe;
  assign req1 = m1_cycle & m1_strobe;

`ifdef SDRAM_ARB_RR_EN
  // last_q = 1 means m1 owned the most recent grant
  logic last_q, last_d;

  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && (req0 | req1))
      last_d = pick1;
  end
`else
  assign pick1 = req1 & ~req0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req0 | req1)
          state_d = pick1 ? OWN1 : OWN0;
      OWN0:
        if (s_ack)      state_d = GAP;
        else if (!req0) state_d = DRAIN;
      OWN1:
        if (s_ack)      state_d = GAP;
        else if (!req1) state_d = DRAIN;
      GAP:
        state_d = IDLE;
      DRAIN:
        if (s_ack) state_d = GAP;
      default:
        state_d = IDLE;
    endcase
    grant_d = {state_d == OWN1, state_d == OWN0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
`ifdef SDRAM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef SDRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant = grant_q;

  // Slave side is quiet outside OWNx so each transfer starts on a fresh edge
  always_comb begin
    s_address   = '0;
    s_writedata = '0;
    s_write     = 1'b0;
    s_cycle     = 1'b0;
    s_strobe    = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_readdata = '0;
    m1_readdata = '0;
    if (state_q == OWN0) begin
      s_address   = m0_address;
      s_writedata = m0_writedata;
      s_write     = m0_write;
      s_cycle     = 1'b1;
      s_strobe    = 1'b1;
      m0_ack      = s_ack;
      m0_readdata = s_readdata;
    end else if (state_q == OWN1) begin
      s_address   = m1_address;
      s_writedata = m1_writedata;
      s_write     = m1_write;
      s_cycle     = 1'b1;
      s_strobe    = 1'b1;
      m1_ack      = s_ack;
      m1_readdata = s_readdata;
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Scoreboard bench for sdram_wb_arbiter with a latency-programmable
// slave model; expected acks are queued as stimulus is driven.
module tb_sdram_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;

  typedef struct {
    int          m;
    logic [15:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_strobe = 0, m0_cycle = 0, m0_write = 0;
  logic          m1_strobe = 0, m1_cycle = 0, m1_write = 0;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_writedata;
  logic [DW-1:0] s_readdata = '0;
  logic          s_strobe, s_cycle, s_write;
  logic          s_ack = 1'b0;
  logic [1:0]    grant;

  int nrun = 0;
  int nfail = 0;

  exp_t       sb[$];
  logic [1:0] glog[$];
  logic [1:0] prev_g = 2'b00;

  logic [15:0] mem[256];
  int          lat = 4;
  int          cnt = 0;
  bit          busy = 0;
  bit          prev_stb = 0;
  int          rises = 0;
  logic [7:0]  sl_addr;
  logic        sl_wr;
  logic [15:0] sl_wd;

  always #5 clk = ~clk;

  sdram_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_strobe(m0_strobe),
    .m0_cycle(m0_cycle), .m0_write(m0_write), .m0_ack(m0_ack),
    .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_strobe(m1_strobe),
    .m1_cycle(m1_cycle), .m1_write(m1_write), .m1_ack(m1_ack),
    .s_address(s_address), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .s_strobe(s_strobe),
    .s_cycle(s_cycle), .s_write(s_write), .s_ack(s_ack),
    .grant(grant)
  );

  // Slave: latch a request, ack it lat cycles later even if cyc drops
  always @(posedge clk) begin
    if (!reset_n) begin
      s_ack = 0;
      s_readdata = '0;
      busy = 0;
      prev_stb = 0;
    end else begin
      #1;
      s_ack = 0;
      s_readdata = '0;
      if (s_strobe && !prev_stb) rises++;
      prev_stb = s_strobe;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          s_ack = 1;
          busy = 0;
          if (sl_wr) mem[sl_addr] = sl_wd;
          else s_readdata = mem[sl_addr];
        end
      end else if (s_cycle && s_strobe) begin
        busy = 1;
        cnt = lat;
        sl_addr = s_address[7:0];
        sl_wr = s_write;
        sl_wd = s_writedata;
      end
    end
  end

  // Ack monitor: every master ack must match the scoreboard head
  always @(negedge clk) begin
    exp_t        e;
    int          gm;
    logic [15:0] gd;
    if (m0_ack || m1_ack) begin
      nrun++;
      gm = m1_ack ? 1 : 0;
      gd = m1_ack ? m1_readdata : m0_readdata;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_ack m%0d data=%h required none",
                 gm, gd);
      end else begin
        e = sb.pop_front();
        if ((m0_ack && m1_ack) || gm != e.m || gd !== e.d) begin
          nfail++;
          $display("FAIL ack_data got m%0d/%h (acks %b%b) required m%0d/%h",
                   gm, gd, m1_ack, m0_ack, e.m, e.d);
        end
      end
    end
    if (grant != 2'b00 && prev_g == 2'b00) glog.push_back(grant);
    prev_g = grant;
  end

  task automatic wait_ack(input int m, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    lat = 4;
    m0_address = 32'h08;
    m1_address = 32'h09;
    {m0_cycle, m0_strobe, m1_cycle, m1_strobe} = 4'b1111;
    repeat (3) @(negedge clk);
    nrun++;
    if (grant !== 2'b00 || s_cycle !== 1'b0 || s_strobe !== 1'b0) begin
      nfail++;
      $display("FAIL reset_outs grant=%b cyc=%b stb=%b required 00/0/0",
               grant, s_cycle, s_strobe);
    end
    nrun++;
    if ({m0_ack, m1_ack} !== 2'b00 || m0_readdata !== '0 ||
        m1_readdata !== '0 || s_address !== '0) begin
      nfail++;
      $display("FAIL reset_master acks=%b rd=%h/%h addr=%h required 0",
               {m0_ack, m1_ack}, m0_readdata, m1_readdata, s_address);
    end
    sb.push_back('{0, mem[8'h08]});
    reset_n = 1;
    repeat (2) @(negedge clk);
    nrun++;
    if (grant !== 2'b01 || s_cycle !== 1'b1 || s_address !== 32'h08) begin
      nfail++;
      $display("FAIL reset_first_grant grant=%b cyc=%b addr=%h required 01/1/08",
               grant, s_cycle, s_address);
    end
    wait_ack(0, 20, ok);
    {m0_cycle, m0_strobe, m1_cycle, m1_strobe} = 4'b0000;
    nrun++;
    if (!ok) begin
      nfail++;
      $display("FAIL reset_ack_timeout m0_ack=%b required 1", m0_ack);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_read();
    bit ok;
    lat = 4;
    m1_address = 32'h10;
    m1_write = 0;
    sb.push_back('{1, 16'hBEEF});
    {m1_cycle, m1_strobe} = 2'b11;
    wait_ack(1, 20, ok);
    nrun++;
    if (!ok || m1_readdata !== 16'hBEEF || m0_ack !== 1'b0) begin
      nfail++;
      $display("FAIL single_read ok=%0d rd=%h m0_ack=%b required 1/beef/0",
               ok, m1_readdata, m0_ack);
    end
    {m1_cycle, m1_strobe} = 2'b00;
    @(negedge clk);
    nrun++;
    if (s_cycle !== 1'b0 || grant !== 2'b00 || m1_ack !== 1'b0) begin
      nfail++;
      $display("FAIL single_gap cyc=%b grant=%b ack=%b required 0/00/0",
               s_cycle, grant, m1_ack);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_contention();
    bit         ok;
    logic [1:0] exp[4];
    int         m;
    int         got;
`ifdef SDRAM_ARB_RR_EN
    exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    lat = 1;
    glog.delete();
    m0_address = 32'h30;
    m1_address = 32'h31;
    m0_write = 0;
    m1_write = 0;
    for (int i = 0; i < 4; i++) begin
      m = (exp[i] == 2'b10) ? 1 : 0;
      sb.push_back('{m, mem[8'h30 + 8'(m)]});
    end
    {m0_cycle, m0_strobe, m1_cycle, m1_strobe} = 4'b1111;
    got = 0;
    for (int i = 0; i < 80 && got < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) got++;
    end
    {m0_cycle, m0_strobe, m1_cycle, m1_strobe} = 4'b0000;
    repeat (3) @(negedge clk);
    nrun++;
    if (got != 4 || glog.size() != 4) begin
      nfail++;
      $display("FAIL contention_count acks=%0d grants=%0d required 4/4",
               got, glog.size());
    end
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      nrun++;
      if (glog[i] !== exp[i]) begin
        nfail++;
        $display("FAIL contention_grant[%0d] got=%b required %b",
                 i, glog[i], exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    lat = 5;
    m0_address = 32'h40;
    m0_write = 0;
    {m0_cycle, m0_strobe} = 2'b11;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = (grant == 2'b01);
    end
    repeat (2) @(negedge clk);
    {m0_cycle, m0_strobe} = 2'b00;
    m1_address = 32'h41;
    m1_write = 0;
    sb.push_back('{1, mem[8'h41]});
    {m1_cycle, m1_strobe} = 2'b11;
    @(negedge clk);
    nrun++;
    if (!ok || grant !== 2'b00 || s_cycle !== 1'b0 || s_ack !== 1'b0) begin
      nfail++;
      $display("FAIL abort_drain ok=%0d grant=%b cyc=%b sack=%b required 1/00/0/0",
               ok, grant, s_cycle, s_ack);
    end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (s_ack) ok = 1;
      else @(negedge clk);
    end
    nrun++;
    if (!ok || m0_ack !== 1'b0 || m1_ack !== 1'b0 ||
        m0_readdata !== '0 || grant !== 2'b00) begin
      nfail++;
      $display("FAIL abort_ack ok=%0d acks=%b%b rd=%h grant=%b required 1/00/0/00",
               ok, m1_ack, m0_ack, m0_readdata, grant);
    end
    @(negedge clk);
    nrun++;
    if (grant !== 2'b00 || s_cycle !== 1'b0) begin
      nfail++;
      $display("FAIL abort_gap grant=%b cyc=%b required 00/0", grant, s_cycle);
    end
    wait_ack(1, 20, ok);
    {m1_cycle, m1_strobe} = 2'b00;
    nrun++;
    if (!ok) begin
      nfail++;
      $display("FAIL abort_next_owner m1_ack=%b required 1", m1_ack);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int r0;
    lat = 2;
    r0 = rises;
    m0_address = 32'h20;
    m0_writedata = 16'h1234;
    m0_write = 1;
    sb.push_back('{0, 16'h0000});
    {m0_cycle, m0_strobe} = 2'b11;
    wait_ack(0, 20, ok1);
    m0_address = 32'h21;
    m0_writedata = 16'h5678;
    sb.push_back('{0, 16'h0000});
    wait_ack(0, 20, ok2);
    {m0_cycle, m0_strobe, m0_write} = 3'b000;
    repeat (6) @(negedge clk);
    nrun++;
    if (!ok1 || !ok2 || rises - r0 != 2) begin
      nfail++;
      $display("FAIL b2b_edges ack1=%0d ack2=%0d rises=%0d required 1/1/2",
               ok1, ok2, rises - r0);
    end
    nrun++;
    if (mem[8'h20] !== 16'h1234 || mem[8'h21] !== 16'h5678) begin
      nfail++;
      $display("FAIL b2b_mem got=%h/%h required 1234/5678",
               mem[8'h20], mem[8'h21]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 16'(i * 16'h0101) ^ 16'hA5A5;
    mem[8'h10] = 16'hBEEF;
    test_reset();
    test_single_read();
    test_contention();
    test_abort();
    test_back_to_back();
    nrun++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_left pending=%0d required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
